fetch_pair_queue: RTL and testbench
===================================

Name: fetch_pair_queue

Overview:
- Dual-issue instruction queue between the 2-way fetch stage and decode.
- Each cycle it accepts the fetched instruction pair (PC, PC+4) and buffers it in a circular FIFO.
- It presents the two oldest instructions to decode and retires 0, 1 or 2 per cycle as decode consumes them.
- It raises the stall that freezes the fetch PC, and it is emptied by a branch redirect (flush).

Parameters:
- DEPTH, 8, number of instruction entries; power of two, minimum 4.
- PC_W, 64, program counter width.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  branch redirect; discards all queued entries.
- in_valid  input  1  the fetch pair on the in_* ports is valid this cycle.
- in_pc  input  PC_W  PC of in_instr1; in_instr2 is at in_pc+4.
- in_instr1  input  INSTR_W  instruction at in_pc.
- in_instr2  input  INSTR_W  instruction at in_pc+4.
- stall  output  1  to fetch: hold PC; the pair is not accepted this cycle.
- deq_cnt  input  2  number of instructions decode consumes this cycle (0..2; the value 3 is treated as 2).
- out_valid1  output  1  slot 1 (oldest entry) is valid.
- out_pc1  output  PC_W  PC of the oldest entry.
- out_instr1  output  INSTR_W  instruction of the oldest entry.
- out_valid2  output  1  slot 2 (second-oldest entry) is valid.
- out_pc2  output  PC_W  PC of the second-oldest entry.
- out_instr2  output  INSTR_W  instruction of the second-oldest entry.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Arrays pc_mem[DEPTH] and instr_mem[DEPTH].
  - Head and tail pointers, log2(DEPTH) bits each, wrap modulo DEPTH.
  - count register, log2(DEPTH)+1 bits.
- Reset (rst=1 at an edge):
  - head, tail and count become 0; all storage entries become 0.
  - Resulting outputs: stall=0, out_valid1=0, out_valid2=0, out_pc*/out_instr* = 0, count = 0.
  - Reset has priority over flush, enqueue and dequeue.
- stall:
  - Combinational from the registered count: stall = (count > DEPTH-2).
  - Computed without crediting a same-cycle dequeue (conservative).
  - Forced 0 while flush=1, so fetch is free to load the branch target.
- Enqueue (enq = in_valid & ~stall & ~flush):
  - pc_mem[tail] <= in_pc; instr_mem[tail] <= in_instr1.
  - pc_mem[tail+1] <= in_pc+4, computed modulo 2^PC_W; instr_mem[tail+1] <= in_instr2.
  - tail <= tail+2, wrapping.
  - The pair is always written atomically; a split pair is never stored.
- Dequeue:
  - deq_eff = min(deq_cnt, count), so dequeue beyond occupancy is clamped silently.
  - head <= head+deq_eff, wrapping.
  - Ignored while flush=1.
- Simultaneous enqueue and dequeue in the same cycle: count <= count + 2*enq - deq_eff.
- Outputs (combinational from storage, zero-latency read):
  - out_valid1 = (count>=1); out_valid2 = (count>=2).
  - Slot 1 reads head; slot 2 reads head+1, wrapping.
  - Data on an invalid slot is don't-care; benches must not check it.
- Latency: a pair accepted at edge N is visible on out_* after edge N. An empty queue fed at edge N shows out_valid1=out_valid2=1 in cycle N+1.
- Flush: at the edge, head, tail and count become 0. The same-cycle in_* pair and deq_cnt are discarded. Storage contents are not cleared.
- Full boundary: with count=DEPTH-1 or DEPTH, stall=1 and the in_* pair is dropped; fetch is required to replay it by holding PC.
- Wrap-around: pointer arithmetic must stay correct when tail=DEPTH-1. The pair then splits across index DEPTH-1 and index 0, and its order must be preserved.
- Invariant: count never exceeds DEPTH and never underflows. Verification asserts this every cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> count=0, stall=0, out_valid1=out_valid2=0.
- Single fill: in_valid=1, in_pc=0x4, in_instr1=0x015A04B3, in_instr2=0x00148493, deq_cnt=0 -> next cycle count=2; out_pc1=0x4 with out_instr1=0x015A04B3; out_pc2=0x8 with out_instr2=0x00148493.
- Fill to full with DEPTH=8 and deq_cnt=0, feeding PCs 0x0, 0x8, 0x10, 0x18, 0x20:
  - After 3 accepted pairs, count=6 and stall=0.
  - After the 4th pair, count=8 and stall=1.
  - The 5th pair (PC 0x20) is dropped and count stays 8.
- Mixed rates:
  - From count=8, deq_cnt=1 -> count=7, stall stays 1.
  - Next deq_cnt=2 -> count=5, stall=0.
  - Then enqueue with deq_cnt=1 in the same cycle -> count=6.
  - Check that out_pc1 advances by 4 per retired instruction across the pointer wrap (index 7 to index 0).
- Over-dequeue: count=1 with deq_cnt=2 -> count=0, no underflow, out_valid1=0.
- Flush mid-stream: with count=6, flush=1 together with in_valid=1 and deq_cnt=2 -> count=0, stall=0.
  - The following cycle, enqueue in_pc=0x14 -> out_pc1=0x14, out_pc2=0x18, count=2.

Source files
------------

// File: rtl/fetch_pair_queue.sv
// ----------------------------------------------------------------------------
// fetch_pair_queue
//
// Dual-issue instruction queue between a 2-way fetch stage and decode.
// Fetch pairs (PC, PC+4) are written atomically into a circular FIFO.
// The two oldest entries are presented to decode, which retires 0..2 per cycle.
// A branch redirect (flush) empties the queue.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-high reset (clears pointers, count, storage)
//   flush       branch redirect; discards all queued entries and same-cycle I/O
//   in_valid    fetch pair on in_* is valid
//   in_pc       PC of in_instr1 (in_instr2 sits at in_pc+4)
//   in_instr1   instruction at in_pc
//   in_instr2   instruction at in_pc+4
//   stall       to fetch: hold PC, the pair is not accepted this cycle
//   deq_cnt     instructions consumed by decode this cycle (3 is treated as 2)
//   out_valid1  slot 1 (oldest entry) valid
//   out_pc1     PC of the oldest entry
//   out_instr1  instruction of the oldest entry
//   out_valid2  slot 2 (second-oldest entry) valid
//   out_pc2     PC of the second-oldest entry
//   out_instr2  instruction of the second-oldest entry
//   count       number of occupied entries
// ----------------------------------------------------------------------------
module fetch_pair_queue #(
    parameter int DEPTH   = 8,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr1,
    input  logic [INSTR_W-1:0] in_instr2,
    output logic               stall,
    input  logic [1:0]         deq_cnt,
    output logic               out_valid1,
    output logic [PC_W-1:0]    out_pc1,
    output logic [INSTR_W-1:0] out_instr1,
    output logic               out_valid2,
    output logic [PC_W-1:0]    out_pc2,
    output logic [INSTR_W-1:0] out_instr2,
    output logic [CNT_W-1:0]   count
);

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] head_p1;
    logic [1:0]       deq_req;
    logic [CNT_W-1:0] deq_eff;
    logic             stall_raw;
    logic             enq;

    // Stall looks only at registered occupancy; a same-cycle dequeue is not
    // credited, which keeps this path short at the cost of one lost slot.
    assign stall_raw = (count_q > CNT_W'(DEPTH - 2));
    assign stall     = stall_raw & ~flush;

    assign enq     = in_valid & ~stall_raw & ~flush;
    assign tail_p1 = tail_q + PTR_W'(1);
    assign head_p1 = head_q + PTR_W'(1);
    assign deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;

    // Decode may ask for more than is present; clamp to occupancy.
    always_comb begin
        deq_eff = CNT_W'(deq_req);
        if (deq_eff > count_q) begin
            deq_eff = count_q;
        end
    end

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;

        if (flush) begin
            // Storage is left as-is; only the bookkeeping is discarded.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                pc_mem_d[tail_q]     = in_pc;
                instr_mem_d[tail_q]  = in_instr1;
                pc_mem_d[tail_p1]    = in_pc + PC_W'(4);
                instr_mem_d[tail_p1] = in_instr2;
                tail_d               = tail_q + PTR_W'(2);
            end
            head_d  = head_q + PTR_W'(deq_eff);
            count_d = count_q + (enq ? CNT_W'(2) : CNT_W'(0)) - deq_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    assign count      = count_q;
    assign out_valid1 = (count_q >= CNT_W'(1));
    assign out_valid2 = (count_q >= CNT_W'(2));
    assign out_pc1    = pc_mem_q[head_q];
    assign out_instr1 = instr_mem_q[head_q];
    assign out_pc2    = pc_mem_q[head_p1];
    assign out_instr2 = instr_mem_q[head_p1];

endmodule

// File: tb/tb_fetch_pair_queue.sv
module tb_fetch_pair_queue;

    localparam int DEPTH   = 8;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr1;
    logic [INSTR_W-1:0] in_instr2;
    logic               stall;
    logic [1:0]         deq_cnt;
    logic               out_valid1;
    logic [PC_W-1:0]    out_pc1;
    logic [INSTR_W-1:0] out_instr1;
    logic               out_valid2;
    logic [PC_W-1:0]    out_pc2;
    logic [INSTR_W-1:0] out_instr2;
    logic [CNT_W-1:0]   count;

    fetch_pair_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr1(in_instr1), .in_instr2(in_instr2),
        .stall(stall), .deq_cnt(deq_cnt),
        .out_valid1(out_valid1), .out_pc1(out_pc1), .out_instr1(out_instr1),
        .out_valid2(out_valid2), .out_pc2(out_pc2), .out_instr2(out_instr2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // Reference model: the queue contents, oldest first.
    entry_t model_q[$];
    bit     check_en = 1'b0;
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One compare process: every cycle, mid-period, DUT vs model.
    always @(negedge clk) begin
        if (check_en) begin
            int n;
            n = model_q.size();
            chk("cnt_le_depth", 64'(count <= CNT_W'(DEPTH)), 64'd1);
            chk("count", 64'(count), 64'(n));
            chk("stall", 64'(stall), 64'(!flush && (n > DEPTH - 2)));
            chk("valid1", 64'(out_valid1), 64'(n >= 1));
            chk("valid2", 64'(out_valid2), 64'(n >= 2));
            if (n >= 1) begin
                chk("pc1", out_pc1, model_q[0].pc);
                chk("instr1", 64'(out_instr1), 64'(model_q[0].instr));
            end
            if (n >= 2) begin
                chk("pc2", out_pc2, model_q[1].pc);
                chk("instr2", 64'(out_instr2), 64'(model_q[1].instr));
            end
        end
    end

    // Drive one cycle of inputs, then advance the model across the edge.
    task automatic tick(input bit r, input bit fl, input bit v, input logic [PC_W-1:0] pc,
                        input logic [INSTR_W-1:0] i1, input logic [INSTR_W-1:0] i2,
                        input logic [1:0] dq);
        int want;
        int d;
        bit full;
        rst = r; flush = fl; in_valid = v; in_pc = pc;
        in_instr1 = i1; in_instr2 = i2; deq_cnt = dq;
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            full = (model_q.size() > DEPTH - 2);
            want = (dq == 2'd3) ? 2 : int'(dq);
            d    = (want < model_q.size()) ? want : model_q.size();
            for (int k = 0; k < d; k++) void'(model_q.pop_front());
            if (v && !full) begin
                model_q.push_back('{pc: pc, instr: i1});
                model_q.push_back('{pc: pc + 64'd4, instr: i2});
            end
        end
        #1;
    endtask

    task automatic idle(input logic [1:0] dq);
        tick(0, 0, 0, '0, '0, '0, dq);
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic [1:0] dq);
        tick(0, 0, 1, pc, INSTR_W'(32'hA000_0000 | pc[31:0]),
             INSTR_W'(32'hB000_0000 | pc[31:0]), dq);
    endtask

    initial begin
        // Reset then idle
        tick(1, 0, 0, '0, '0, '0, 2'd0);
        check_en = 1'b1;
        tick(1, 0, 0, '0, '0, '0, 2'd0);
        idle(2'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_valid1", 64'(out_valid1), 64'd0);
        chk("rst_valid2", 64'(out_valid2), 64'd0);
        chk("rst_pc1", out_pc1, 64'd0);
        chk("rst_instr1", 64'(out_instr1), 64'd0);

        // Single fill
        tick(0, 0, 1, 64'h4, 32'h015A04B3, 32'h00148493, 2'd0);
        chk("fill_count", 64'(count), 64'd2);
        chk("fill_pc1", out_pc1, 64'h4);
        chk("fill_instr1", 64'(out_instr1), 64'h015A04B3);
        chk("fill_pc2", out_pc2, 64'h8);
        chk("fill_instr2", 64'(out_instr2), 64'h00148493);
        idle(2'd2);
        chk("drain_count", 64'(count), 64'd0);

        // Fill to full (tail starts at 2, so the 4th pair wraps to index 0)
        push(64'h0, 2'd0);
        push(64'h8, 2'd0);
        push(64'h10, 2'd0);
        chk("three_count", 64'(count), 64'd6);
        chk("three_stall", 64'(stall), 64'd0);
        push(64'h18, 2'd0);
        chk("four_count", 64'(count), 64'd8);
        chk("four_stall", 64'(stall), 64'd1);
        push(64'h20, 2'd0);
        chk("drop_count", 64'(count), 64'd8);

        // Mixed rates
        idle(2'd1);
        chk("mix7_count", 64'(count), 64'd7);
        chk("mix7_stall", 64'(stall), 64'd1);
        chk("mix7_pc1", out_pc1, 64'h4);
        idle(2'd2);
        chk("mix5_count", 64'(count), 64'd5);
        chk("mix5_stall", 64'(stall), 64'd0);
        chk("mix5_pc1", out_pc1, 64'hC);
        push(64'h100, 2'd1);
        chk("mix6_count", 64'(count), 64'd6);
        chk("mix6_pc1", out_pc1, 64'h10);
        idle(2'd1);
        chk("wrap_pc1_a", out_pc1, 64'h14);
        idle(2'd1);
        chk("wrap_pc1_b", out_pc1, 64'h18);
        chk("wrap_pc2_b", out_pc2, 64'h1C);

        // Flush mid-stream
        push(64'h200, 2'd0);
        chk("pre_flush_count", 64'(count), 64'd6);
        tick(0, 1, 1, 64'h300, 32'h1, 32'h2, 2'd2);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_stall", 64'(stall), 64'd0);
        tick(0, 0, 1, 64'h14, 32'h11111111, 32'h22222222, 2'd0);
        chk("postflush_pc1", out_pc1, 64'h14);
        chk("postflush_pc2", out_pc2, 64'h18);
        chk("postflush_count", 64'(count), 64'd2);

        // Over-dequeue and deq_cnt=3
        idle(2'd1);
        chk("over_pre_count", 64'(count), 64'd1);
        idle(2'd2);
        chk("over_count", 64'(count), 64'd0);
        chk("over_valid1", 64'(out_valid1), 64'd0);
        push(64'h40, 2'd0);
        idle(2'd3);
        chk("deq3_count", 64'(count), 64'd0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            if (i == 37) tick(0, 1, 1, 64'hDEAD, 32'h5, 32'h6, 2'd1);
            else tick(0, 0, (i % 3) != 0, 64'h1000 + 64'(8 * i),
                      INSTR_W'(32'hC000_0000 + i), INSTR_W'(32'hD000_0000 + i),
                      2'(i % 4));
        end

        // Reset has priority over flush/enqueue
        tick(1, 1, 1, 64'h50, 32'h7, 32'h8, 2'd2);
        chk("rst_prio_count", 64'(count), 64'd0);
        chk("rst_prio_pc1", out_pc1, 64'd0);
        idle(2'd0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
